// File: rtl/lif_sched_pkg.sv
// lif_sched_pkg: shared FSM encodings, float constants and index sizing for the LIF timestep scheduler.
package lif_sched_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [31:0] FP_ZERO             = 32'h0000_0000;
    localparam logic [31:0] V_THRESHOLD_DEFAULT = 32'h4220_0000;

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/lif_update_core.sv
// lif_update_core: combinational LIF step, sum = v + w; fire when sum > threshold, then subtract threshold.
module lif_update_core
    import lif_sched_pkg::*;
(
    input  logic [31:0] potential_i,
    input  logic [31:0] weight_i,
    input  logic [31:0] threshold_i,
    output logic [31:0] new_potential_o,
    output logic        spike_o
);
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, r;
        logic [9:0]  ea, eb, d, e, lz, sh;
        logic [50:0] wide;
        logic [26:0] ma, mb, mn;
        logic [27:0] s;
        logic        rnd;
        if (&x[30:23] && |x[22:0]) return x;
        if (&y[30:23] && |y[22:0]) return y;
        if (&x[30:23]) return (&y[30:23] && (x[31] != y[31])) ? 32'h7FC0_0000 : x;
        if (&y[30:23]) return y;
        {a, b} = (x[30:0] >= y[30:0]) ? {x, y} : {y, x};
        ea = (a[30:23] == 8'd0) ? 10'd1 : {2'b0, a[30:23]};
        eb = (b[30:23] == 8'd0) ? 10'd1 : {2'b0, b[30:23]};
        d = ea - eb;
        ma = {|a[30:23], a[22:0], 3'b000};
        wide = {|b[30:23], b[22:0], 27'b0} >> ((d > 10'd31) ? 10'd31 : d);
        // guard and round bits kept, everything below folded into sticky
        mb = {wide[50:25], |wide[24:0]};
        s = (a[31] ^ b[31]) ? {1'b0, ma} - {1'b0, mb} : {1'b0, ma} + {1'b0, mb};
        if (s == 28'd0) return (a[31] & b[31]) ? 32'h8000_0000 : FP_ZERO;
        if (s[27]) begin
            mn = {s[27:2], |s[1:0]};
            e = ea + 10'd1;
        end else begin
            lz = 10'd27;
            for (int i = 0; i < 27; i++) if (s[i]) lz = 10'(26 - i);
            sh = (lz < ea) ? lz : ea - 10'd1;
            mn = s[26:0] << sh;
            e = mn[26] ? ea - sh : 10'd0;
        end
        if (e >= 10'd255) return {a[31], 8'hFF, 23'h0};
        r = {a[31], e[7:0], mn[25:3]};
        rnd = mn[2] & (mn[1] | mn[0] | mn[3]);
        return r + {31'b0, rnd};
    endfunction

    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return !a[31];
        return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    endfunction

    logic [31:0] sum;

    assign sum             = fp_add(potential_i, weight_i);
    assign spike_o         = fp_gt(sum, threshold_i);
    assign new_potential_o = spike_o ? fp_add(sum, {~threshold_i[31], threshold_i[30:0]}) : sum;
endmodule

// File: rtl/lif_timestep_scheduler.sv
// lif_timestep_scheduler: walks one shared LIF update core over all neurons once per timestep.
// Define LIF_REFRACTORY_EN to give each neuron a one-timestep refractory period after it fires.
module lif_timestep_scheduler
    import lif_sched_pkg::*;
#(
    parameter int          NUM_NEURONS   = 30,
    parameter int          IDX_W         = idx_width(NUM_NEURONS),
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] V_THRESHOLD   = V_THRESHOLD_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   start,
    input  logic                   clear_potentials,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [31:0]            w_data,
    output logic [IDX_W-1:0]       cur_idx,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   done,
    output logic                   busy,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [31:0]            rd_data
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    logic [2:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [31:0]            opnd_q, opnd_d;
    logic [31:0]            pot_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] shadow_q, spike_vec_q;
    logic [31:0]            cur_pot, core_pot, wr_pot;
    logic                   core_spk, wr_spk, refr_cur;

    assign cur_pot = pot_q[idx_q];

    lif_update_core u_core (
        .potential_i    (cur_pot),
        .weight_i       (opnd_q),
        .threshold_i    (V_THRESHOLD),
        .new_potential_o(core_pot),
        .spike_o        (core_spk)
    );

`ifdef LIF_REFRACTORY_EN
    logic [NUM_NEURONS-1:0] refr_q;
    assign refr_cur = refr_q[idx_q];
    always_ff @(posedge CLK) begin
        if (!RESET_N || (state_q == S_IDLE && clear_potentials)) refr_q <= '0;
        else if (state_q == S_WRITE) refr_q[idx_q] <= wr_spk;
    end
`else
    assign refr_cur = 1'b0;
`endif

    // a refractory neuron swallows its weight and keeps its potential
    assign wr_pot = refr_cur ? cur_pot : core_pot;
    assign wr_spk = !refr_cur && core_spk;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FETCH;
                idx_d   = '0;
            end
            S_FETCH: if (w_valid) begin
                opnd_d  = w_data;
                cnt_d   = 4'(SETTLE_CYCLES);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? S_WRITE : S_SETTLE;
            end
            S_WRITE: begin
                state_d = (idx_q == LAST) ? S_FINISH : S_FETCH;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            opnd_q      <= FP_ZERO;
            shadow_q    <= '0;
            spike_vec_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= FP_ZERO;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            if (state_q == S_IDLE && clear_potentials)
                for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= FP_ZERO;
            if (state_q == S_IDLE && start) shadow_q <= '0;
            if (state_q == S_WRITE) begin
                pot_q[idx_q]    <= wr_pot;
                shadow_q[idx_q] <= wr_spk;
            end
            if (state_q == S_FINISH) spike_vec_q <= shadow_q;
        end
    end

    assign w_ready   = (state_q == S_FETCH);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign cur_idx   = idx_q;
    assign spike_vec = spike_vec_q;
    assign rd_data   = (int'(rd_idx) < NUM_NEURONS) ? pot_q[rd_idx] : FP_ZERO;
endmodule
